// File: rtl/mm_pkg.sv
// Shared constants, streamer state encoding and the requantization helper
// used by the result streamer.
package mm_pkg;
  localparam int T    = 16;
  localparam int W    = 8;
  localparam int ACCW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } streamer_state_t;

  // Round-half-up arithmetic shift, one guard bit wide so the rounding add
  // cannot wrap, then clamp into the signed W-bit range.
  function automatic logic signed [W-1:0] sat_round(input logic signed [ACCW-1:0] acc,
                                                    input logic [4:0] shamt);
    logic signed [ACCW:0] ext;
    logic signed [ACCW:0] rnd;
    logic signed [ACCW:0] r;
    logic signed [ACCW:0] qmax;
    logic signed [ACCW:0] qmin;
    ext  = {acc[ACCW-1], acc};
    rnd  = '0;
    if (shamt != 5'd0) rnd = (ACCW+1)'(1) <<< (shamt - 5'd1);
    r    = (ext + rnd) >>> shamt;
    qmax = (ACCW+1)'((2 ** (W-1)) - 1);
    qmin = (ACCW+1)'(-(2 ** (W-1)));
    if (r > qmax)      sat_round = {1'b0, {(W-1){1'b1}}};
    else if (r < qmin) sat_round = {1'b1, {(W-1){1'b0}}};
    else               sat_round = r[W-1:0];
  endfunction
endpackage

// File: rtl/c_result_streamer_if.sv
// Output beat stream of the result streamer: valid/ready plus raw value,
// requantized value and element coordinates.
interface c_result_streamer_if #(
  parameter int T    = mm_pkg::T,
  parameter int W    = mm_pkg::W,
  parameter int ACCW = mm_pkg::ACCW
);
  localparam int RW = (T > 1) ? $clog2(T) : 1;

  logic                   valid;
  logic                   ready;
  logic signed [ACCW-1:0] data;
  logic signed [W-1:0]    q;
  logic [RW-1:0]          row;
  logic [RW-1:0]          col;
  logic                   last;

  modport master (output valid, data, q, row, col, last, input ready);
  modport slave  (input valid, data, q, row, col, last, output ready);
endinterface

// File: rtl/result_skid_fifo.sv
// Two-entry registered FIFO holding packed output beats; only the pointers
// and occupancy are reset, the storage is plain data.
module result_skid_fifo #(
  parameter int DW = 8
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [1:0]    count
);
  logic [DW-1:0] mem_q [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= wdata;
  end

  assign rdata = mem_q[rd_ptr];
  assign count = cnt;
endmodule

// File: rtl/c_result_streamer.sv
// Reads a T x T accumulator tile from BRAM C in row-major order and streams
// each element out with its requantized copy over a valid/ready interface.
module c_result_streamer #(
  parameter int T       = mm_pkg::T,
  parameter int W       = mm_pkg::W,
  parameter int ACCW    = mm_pkg::ACCW,
  parameter int BRAM_AW = 8
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [4:0]                  shift_amt,
  output logic                        busy,
  output logic                        done,
  output logic [T-1:0]                bram_c_en,
  output logic [T-1:0][BRAM_AW-1:0]   bram_c_addr,
  input  logic [T-1:0][ACCW-1:0]      bram_c_rdata,
  c_result_streamer_if.master         m
);
  import mm_pkg::*;

  localparam int RW = (T > 1) ? $clog2(T) : 1;
  localparam int BW = ACCW + W + 2 * RW + 1;
  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_STREAM = STREAM;
  localparam logic [1:0] ST_FLUSH  = FLUSH;
  localparam logic [1:0] ST_DONE   = DONE;

  logic [1:0]          state;
  logic [4:0]          shamt;
  logic [RW-1:0]       row_p0, col_p0;
  logic [RW-1:0]       row_p1, col_p1;
  logic                last_p1, vld_p1;
  logic                issue, last_issue, pop;
  logic [2:0]          occ;
  logic [1:0]          fifo_count;
  logic [BW-1:0]       fifo_wdata, fifo_rdata;
  logic signed [W-1:0] q_p1;
  logic [ACCW-1:0]     head_data;
  logic [W-1:0]        head_q;
  logic [RW-1:0]       head_row, head_col;
  logic                head_last;

  assign pop        = m.valid & m.ready;
  // Reads in flight count as occupied slots so the 2-deep FIFO never overflows.
  assign occ        = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue      = (state == ST_STREAM) && (occ < 3'd2);
  assign last_issue = (row_p0 == RW'(T - 1)) && (col_p0 == RW'(T - 1));
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

  always_comb begin
    bram_c_en   = '0;
    bram_c_addr = '0;
    if (issue) begin
      bram_c_en[row_p0]   = 1'b1;
      bram_c_addr[row_p0] = BRAM_AW'(col_p0);
    end
  end

  // p0: read issue and row/col walk
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      shamt  <= 5'd0;
      row_p0 <= '0;
      col_p0 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue) begin
        if (col_p0 == RW'(T - 1)) begin
          col_p0 <= '0;
          row_p0 <= row_p0 + 1'b1;
        end else begin
          col_p0 <= col_p0 + 1'b1;
        end
      end
      case (state)
        ST_IDLE: if (start) begin
          shamt  <= shift_amt;
          row_p0 <= '0;
          col_p0 <= '0;
          state  <= ST_STREAM;
        end
        ST_STREAM: if (issue && last_issue) state <= ST_FLUSH;
        ST_FLUSH:  if (!vld_p1 && (fifo_count == {1'b0, pop})) state <= ST_DONE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      row_p1  <= row_p0;
      col_p1  <= col_p0;
      last_p1 <= last_issue;
    end
  end

  // p1: BRAM data returns, requantize and enqueue
  assign q_p1       = W'(sat_round(bram_c_rdata[row_p1], shamt));
  assign fifo_wdata = {last_p1, row_p1, col_p1, q_p1, bram_c_rdata[row_p1]};

  result_skid_fifo #(.DW(BW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p1),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  // p2: FIFO head drives the stream; fields read zero while empty
  assign {head_last, head_row, head_col, head_q, head_data} = fifo_rdata;
  assign m.valid = (fifo_count != 2'd0);
  assign m.data  = m.valid ? head_data : '0;
  assign m.q     = m.valid ? head_q    : '0;
  assign m.row   = m.valid ? head_row  : '0;
  assign m.col   = m.valid ? head_col  : '0;
  assign m.last  = m.valid & head_last;
endmodule
